// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Architectural zero register: reads as 0, never written, never busy.
  localparam int ZERO_REG = 0;

  // Widest busy vector popcount() accepts. Callers zero-extend narrower vectors.
  localparam int POPCNT_MAX = 1024;

  // Number of set bits in a busy vector.
  function automatic int unsigned popcount(input logic [POPCNT_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Register scoreboard: one busy bit per register, the reservation grant and a
// registered count of busy registers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic          rsv_req,
  input  logic [AW-1:0] rsv_addr,
  output logic          rsv_gnt,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]   busy_cnt
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             wb_live;
  logic             rsv_live;

  assign wb_live  = wb_en && (wb_addr != ZERO_ADDR);
  assign rsv_live = rsv_gnt && (rsv_addr != ZERO_ADDR);

  // Grant when the destination is free, is x0, or is being released this very cycle.
  assign rsv_gnt = rsv_req &&
                   ((rsv_addr == ZERO_ADDR) ||
                    !busy_q[rsv_addr] ||
                    (wb_en && (wb_addr == rsv_addr)));

  // Next busy state: writeback releases first, then a grant sets, so a grant on
  // the register being written back leaves it busy for the new producer.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    busy_nxt = busy_q;
    if (wb_live)  busy_nxt[wb_addr]  = 1'b0;
    if (rsv_live) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy bits and their count advance together, so the count always matches.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_nxt;
      busy_cnt <= (AW+1)'(popcount(POPCNT_MAX'(busy_nxt)));
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with writeback bypass and a busy-bit
// scoreboard for issue-stage reservations.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   rsv_req,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   rsv_gnt,
  output logic [NREGS-1:0]       busy_vec,
  output logic [AW:0]            busy_cnt
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREGS];

  regfile_sb #(
    .NREGS (NREGS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .rsv_req  (rsv_req),
    .rsv_addr (rsv_addr),
    .rsv_gnt  (rsv_gnt),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  // Register storage: cleared by reset, written by writeback except to x0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the whole array is cleared on reset because software may read any
      // register before writing it; this keeps the file in flops, not a RAM macro.
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_en && (wb_addr != ZERO_ADDR)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read ports: x0 is hard zero, a same-cycle writeback is forwarded and is by
  // definition no longer pending, otherwise storage and the busy bit are used.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_addr[i*AW +: AW] == ZERO_ADDR) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end else if (wb_en && (wb_addr == rd_addr[i*AW +: AW])) begin
        rd_data[i*XLEN +: XLEN] = wb_data;
        rd_busy[i]              = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
        rd_busy[i]              = busy_vec[rd_addr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: a reference model predicts every
// observable output each cycle into a scoreboard queue, plus directed checks.
module tb_regfile_mp_sb;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   rsv_req;
  logic [AW-1:0]          rsv_addr;
  logic                   rsv_gnt;
  logic [NREGS-1:0]       busy_vec;
  logic [AW:0]            busy_cnt;

  regfile_mp_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rsv_req  (rsv_req),
    .rsv_addr (rsv_addr),
    .rsv_gnt  (rsv_gnt),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0][XLEN-1:0] data;
    logic [1:0]           busy;
    logic                 gnt;
    logic [NREGS-1:0]     bvec;
    logic [AW:0]          cnt;
  } exp_t;

  exp_t expq[$];

  logic [XLEN-1:0]  regs_m [NREGS];
  logic [NREGS-1:0] busy_m;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_gnt();
    return rsv_req && ((rsv_addr == 0) || !busy_m[rsv_addr] ||
                       (wb_en && (wb_addr == rsv_addr)));
  endfunction

  // Predict current outputs from the model and the driven inputs.
  function automatic exp_t predict();
    exp_t e;
    logic [AW-1:0] a;
    e = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = rd_addr[p*AW +: AW];
      if (a == 0) begin
        e.data[p] = '0;
        e.busy[p] = 1'b0;
      end else if (wb_en && wb_addr == a) begin
        e.data[p] = wb_data;
        e.busy[p] = 1'b0;
      end else begin
        e.data[p] = regs_m[a];
        e.busy[p] = busy_m[a];
      end
    end
    e.gnt  = model_gnt();
    e.bvec = busy_m;
    e.cnt  = (AW+1)'($countones(busy_m));
    return e;
  endfunction

  // Push a prediction, then at the falling edge pop it and compare.
  task automatic sample();
    exp_t e;
    expq.push_back(predict());
    @(negedge clk);
    e = expq.pop_front();
    check("rd_data0", 64'(rd_data[31:0]),  64'(e.data[0]));
    check("rd_data1", 64'(rd_data[63:32]), 64'(e.data[1]));
    check("rd_busy",  64'(rd_busy),        64'(e.busy));
    check("rsv_gnt",  64'(rsv_gnt),        64'(e.gnt));
    check("busy_vec", 64'(busy_vec),       64'(e.bvec));
    check("busy_cnt", 64'(busy_cnt),       64'(e.cnt));
  endtask

  // Advance one clock edge and update the model with the pre-edge inputs.
  task automatic tick();
    logic g;
    @(posedge clk);
    g = model_gnt();
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs_m[r] = '0;
      busy_m = '0;
    end else begin
      if (wb_en && wb_addr != 0) begin
        regs_m[wb_addr] = wb_data;
        busy_m[wb_addr] = 1'b0;
      end
      if (g && rsv_addr != 0) busy_m[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rsv_req = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NREGS; r++) regs_m[r] = 'x;
    busy_m = 'x;
    rst = 1'b0;
    idle();
    set_rd(0, 0);
    tick();
    tick();
    rst = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = AW'($urandom);
      wb_data  = $urandom;
      rsv_req  = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom);
      set_rd((n % 3 == 0) ? wb_addr : AW'($urandom), (n % 4 == 0) ? rsv_addr : AW'($urandom));
      sample();
      tick();
    end

    // Reset held two cycles with traffic present: everything clears.
    rst = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hAAAA5555;
    rsv_req = 1'b1; rsv_addr = 5'd13;
    tick();
    tick();
    rst = 1'b1;
    idle();
    for (int k = 0; k < NREGS / 2; k++) begin
      set_rd(AW'(2 * k), AW'(2 * k + 1));
      sample();
      check("rst_rd0", 64'(rd_data[31:0]), 64'd0);
      check("rst_rd1", 64'(rd_data[63:32]), 64'd0);
      tick();
    end
    check("rst_busy_vec", 64'(busy_vec), 64'd0);
    check("rst_busy_cnt", 64'(busy_cnt), 64'd0);

    // Write x5 with same-cycle bypass, then from storage; x6 stays 0.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    set_rd(5, 6);
    sample();
    check("bypass_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("read_x6", 64'(rd_data[63:32]), 64'd0);
    tick();
    idle();
    sample();
    check("stored_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    tick();

    // x0: write dropped, reservation granted without effect.
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    rsv_req = 1'b1; rsv_addr = 5'd0;
    set_rd(0, 0);
    sample();
    check("gnt_x0", 64'(rsv_gnt), 64'd1);
    check("read_x0", 64'(rd_data[31:0]), 64'd0);
    tick();
    idle();
    sample();
    check("x0_after", 64'(rd_data[31:0]), 64'd0);
    check("x0_busy", 64'(busy_vec[0]), 64'd0);
    check("x0_cnt", 64'(busy_cnt), 64'd0);
    tick();

    // Scoreboard on x7: reserve, refuse a second reservation, release by wb.
    rsv_req = 1'b1; rsv_addr = 5'd7;
    set_rd(7, 7);
    sample();
    check("gnt_x7", 64'(rsv_gnt), 64'd1);
    check("x7_not_yet", 64'(rd_busy), 64'd0);
    tick();
    sample();
    check("x7_busy", 64'(rd_busy), 64'b11);
    check("x7_cnt", 64'(busy_cnt), 64'd1);
    check("gnt_x7_again", 64'(rsv_gnt), 64'd0);
    tick();
    idle();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12;
    sample();
    check("x7_wb_busy", 64'(rd_busy), 64'd0);
    check("x7_wb_data", 64'(rd_data[31:0]), 64'h12);
    tick();
    idle();
    sample();
    check("x7_cnt_clear", 64'(busy_cnt), 64'd0);
    tick();

    // Simultaneous writeback and reservation on x9: data written, busy stays.
    rsv_req = 1'b1; rsv_addr = 5'd9;
    tick();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h34;
    set_rd(9, 0);
    sample();
    check("gnt_x9_sim", 64'(rsv_gnt), 64'd1);
    tick();
    idle();
    sample();
    check("x9_data", 64'(rd_data[31:0]), 64'h34);
    check("x9_busy", 64'(rd_busy[0]), 64'd1);
    check("x9_vec", 64'(busy_vec), 64'(32'h1 << 9));
    check("x9_cnt", 64'(busy_cnt), 64'd1);
    tick();

    // Reset mid-operation overrides a writeback and a reservation.
    rsv_req = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd4;
    tick();
    idle();
    set_rd(3, 4);
    sample();
    check("pre_rst_cnt", 64'(busy_cnt), 64'd3);
    rst = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h77;
    rsv_req = 1'b1; rsv_addr = 5'd8;
    tick();
    rst = 1'b1;
    idle();
    set_rd(3, 8);
    sample();
    check("mid_rst_vec", 64'(busy_vec), 64'd0);
    check("mid_rst_x3", 64'(rd_data[31:0]), 64'd0);
    check("mid_rst_x8", 64'(rd_busy[1]), 64'd0);
    check("mid_rst_cnt", 64'(busy_cnt), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
